// File: rtl/exhaustive_pattern_sweeper.sv
// exhaustive_pattern_sweeper
// Walks every IN_W-bit stimulus pattern in binary or Gray order. Each pattern
// is held for SETTLE cycles before the DUT response is sampled. Every
// pattern/response record goes out on a valid/ready port, and each accepted
// record is folded into a MISR signature.
// Optional feature: define SWEEPER_MISR_EN to build the MISR. Without it,
// signature is tied to zero.
module exhaustive_pattern_sweeper #(
    parameter int IN_W   = 5,
    parameter int OUT_W  = 1,
    parameter int SETTLE = 1,
    parameter int SIG_W  = 16,
    parameter logic [SIG_W-1:0] POLY = SIG_W'(16'h1021)
) (
    input  logic               CK,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic               mode,
    output logic [IN_W-1:0]    stim,
    input  logic [OUT_W-1:0]   resp,
    output logic               rec_valid,
    input  logic               rec_ready,
    output logic [IN_W-1:0]    rec_pattern,
    output logic [OUT_W-1:0]   rec_resp,
    output logic               busy,
    output logic               done,
    output logic [SIG_W-1:0]   signature
);

    localparam int CNT_W = IN_W + 1;
    localparam int SC_W  = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    // cnt carries one extra bit, so the final pattern compares without wrap.
    localparam logic [CNT_W-1:0] LAST_CNT = {1'b0, {IN_W{1'b1}}};

    typedef enum logic [1:0] {IDLE, APPLY, EMIT, DONE} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  gray;
    logic [SC_W-1:0]   scnt;
    logic              mode_q;
    logic [IN_W-1:0]   pat;
    logic              go;
    logic              settle_last;
    logic              accept;

    assign go          = start && !abort;
    assign settle_last = (scnt == SC_W'(SETTLE - 1));
    assign accept      = (state == EMIT) && rec_ready && !abort;
    assign gray        = cnt ^ (cnt >> 1);
    assign pat         = mode_q ? gray[IN_W-1:0] : cnt[IN_W-1:0];

    // Stimulus is driven only while a sweep is active.
    always_comb begin
        stim = '0;
        if (state == APPLY || state == EMIT)
            stim = pat;
    end

    // State register.
    always_ff @(posedge CK or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic and status outputs. Abort wins over a handshake.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        rec_valid = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (go) state_nxt = APPLY;
            APPLY: begin
                busy = 1'b1;
                if (abort)            state_nxt = IDLE;
                else if (settle_last) state_nxt = EMIT;
            end
            EMIT: begin
                busy      = 1'b1;
                rec_valid = 1'b1;
                if (abort)          state_nxt = IDLE;
                else if (rec_ready) state_nxt = (cnt == LAST_CNT) ? DONE : APPLY;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Pattern index, settle timer and record capture.
    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            cnt         <= '0;
            scnt        <= '0;
            mode_q      <= 1'b0;
            rec_pattern <= '0;
            rec_resp    <= '0;
        end else begin
            case (state)
                IDLE: if (go) begin
                    mode_q <= mode;
                    cnt    <= '0;
                    scnt   <= '0;
                end
                APPLY: if (!abort) begin
                    if (settle_last) begin
                        rec_pattern <= pat;
                        rec_resp    <= resp;
                        scnt        <= '0;
                    end else begin
                        scnt <= scnt + SC_W'(1);
                    end
                end
                EMIT: if (accept) cnt <= cnt + CNT_W'(1);
                default: ;
            endcase
        end
    end

`ifdef SWEEPER_MISR_EN
    logic [SIG_W-1:0] sig;
    logic [SIG_W-1:0] data_w;

    // The pattern sits above the response in the zero-extended data word.
    assign data_w = SIG_W'({rec_pattern, rec_resp});

    // MISR: clears on start and compacts each accepted record.
    always_ff @(posedge CK or negedge reset) begin
        if (!reset)
            sig <= '0;
        else if (state == IDLE && go)
            sig <= '0;
        else if (accept)
            sig <= {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ data_w;
    end

    assign signature = sig;
`else
    assign signature = '0;
`endif

endmodule

// File: tb/tb_exhaustive_pattern_sweeper.sv
// Directed bench for exhaustive_pattern_sweeper. It uses three instances:
//   a: IN_W=5, SETTLE=1 (sweep order, back-pressure, abort, reset)
//   b: IN_W=1 (signature value)
//   c: IN_W=2, SETTLE=3 (response sampling point)
module tb_exhaustive_pattern_sweeper;

    logic CK = 1'b0;
    always #5 CK = ~CK;
    logic rst_n;

    logic a_start, a_abort, a_mode, a_ready, a_resp, a_rec_valid, a_rec_resp, a_busy, a_done;
    logic [4:0] a_stim, a_rec_pattern;
    logic [15:0] a_sig;
    assign a_resp = ^a_stim;

    logic b_start, b_abort, b_mode, b_ready, b_resp, b_rec_valid, b_rec_resp, b_busy, b_done;
    logic [0:0] b_stim, b_rec_pattern;
    logic [15:0] b_sig;
    assign b_resp = 1'b0;

    logic c_start, c_abort, c_mode, c_ready, c_resp, c_rec_valid, c_rec_resp, c_busy, c_done;
    logic [1:0] c_stim, c_rec_pattern;
    logic [15:0] c_sig;

    exhaustive_pattern_sweeper #(.IN_W(5), .OUT_W(1), .SETTLE(1)) u_a (
        .CK(CK), .reset(rst_n), .start(a_start), .abort(a_abort), .mode(a_mode),
        .stim(a_stim), .resp(a_resp), .rec_valid(a_rec_valid), .rec_ready(a_ready),
        .rec_pattern(a_rec_pattern), .rec_resp(a_rec_resp), .busy(a_busy),
        .done(a_done), .signature(a_sig));

    exhaustive_pattern_sweeper #(.IN_W(1), .OUT_W(1), .SETTLE(1)) u_b (
        .CK(CK), .reset(rst_n), .start(b_start), .abort(b_abort), .mode(b_mode),
        .stim(b_stim), .resp(b_resp), .rec_valid(b_rec_valid), .rec_ready(b_ready),
        .rec_pattern(b_rec_pattern), .rec_resp(b_rec_resp), .busy(b_busy),
        .done(b_done), .signature(b_sig));

    exhaustive_pattern_sweeper #(.IN_W(2), .OUT_W(1), .SETTLE(3)) u_c (
        .CK(CK), .reset(rst_n), .start(c_start), .abort(c_abort), .mode(c_mode),
        .stim(c_stim), .resp(c_resp), .rec_valid(c_rec_valid), .rec_ready(c_ready),
        .rec_pattern(c_rec_pattern), .rec_resp(c_rec_resp), .busy(c_busy),
        .done(c_done), .signature(c_sig));

    int total = 0;
    int bad   = 0;

    logic [4:0] rec_pat [0:63];
    logic       rec_rsp [0:63];
    int n_rec, n_done, done_cyc;

    function automatic logic [15:0] misr(input logic [15:0] s, input logic [15:0] d);
        return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ d;
    endfunction

    // Expected signature of instance a after nrec accepted records.
    function automatic logic [15:0] exp_sig_a(input logic m, input int nrec);
        logic [15:0] s;
        logic [4:0]  p;
        s = '0;
        for (int k = 0; k < nrec; k++) begin
            p = m ? 5'(k ^ (k >> 1)) : 5'(k);
            s = misr(s, {10'b0, p, ^p});
        end
`ifdef SWEEPER_MISR_EN
        return s;
`else
        return 16'h0000;
`endif
    endfunction

    // Start instance a and collect its records for a bounded window.
    task automatic run_a(input logic m);
        n_rec = 0; n_done = 0; done_cyc = -1;
        a_mode = m; a_ready = 1'b1;
        @(negedge CK) a_start = 1'b1;
        @(negedge CK) a_start = 1'b0;
        for (int cyc = 0; cyc < 80; cyc++) begin
            if (a_rec_valid && n_rec < 64) begin
                rec_pat[n_rec] = a_rec_pattern; rec_rsp[n_rec] = a_rec_resp; n_rec++;
            end
            if (a_done) begin n_done++; if (done_cyc < 0) done_cyc = cyc; end
            @(negedge CK);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        a_start = 0; a_abort = 0; a_mode = 0; a_ready = 1;
        b_start = 0; b_abort = 0; b_mode = 0; b_ready = 1;
        c_start = 0; c_abort = 0; c_mode = 0; c_ready = 1; c_resp = 0;
        #12;
        total++;
        if ({a_stim, a_rec_valid, a_rec_pattern, a_rec_resp, a_busy, a_done, a_sig} !== '0) begin
            bad++; $display("FAIL reset_vals: got %h required 0",
                {a_stim, a_rec_valid, a_rec_pattern, a_rec_resp, a_busy, a_done, a_sig});
        end
        @(negedge CK) rst_n = 1'b1;
        @(negedge CK);
        total++;
        if (a_busy !== 1'b0 || a_stim !== 5'd0) begin
            bad++; $display("FAIL idle_after_reset: busy=%b stim=%h", a_busy, a_stim);
        end
    endtask

    task automatic test_ascending;
        run_a(1'b0);
        total++;
        if (n_rec !== 32) begin bad++; $display("FAIL asc_count: got %0d required 32", n_rec); end
        for (int k = 0; k < 32; k++) begin
            total++;
            if (rec_pat[k] !== 5'(k) || rec_rsp[k] !== ^(5'(k))) begin
                bad++; $display("FAIL asc_rec%0d: got %h/%b required %h/%b",
                    k, rec_pat[k], rec_rsp[k], 5'(k), ^(5'(k)));
            end
        end
        total++;
        if (n_done !== 1 || done_cyc !== 64) begin
            bad++; $display("FAIL asc_done: pulses=%0d at %0d required 1 at 64", n_done, done_cyc);
        end
        total++;
        if (a_busy !== 1'b0) begin bad++; $display("FAIL asc_busy_end: got %b required 0", a_busy); end
        total++;
        if (a_sig !== exp_sig_a(1'b0, 32)) begin
            bad++; $display("FAIL asc_sig: got %h required %h", a_sig, exp_sig_a(1'b0, 32));
        end
    endtask

    task automatic test_gray;
        run_a(1'b1);
        total++;
        if (n_rec !== 32) begin bad++; $display("FAIL gray_count: got %0d required 32", n_rec); end
        for (int k = 0; k < 32; k++) begin
            total++;
            if (rec_pat[k] !== 5'(k ^ (k >> 1)) || rec_rsp[k] !== ^rec_pat[k]) begin
                bad++; $display("FAIL gray_rec%0d: got %h required %h", k, rec_pat[k], 5'(k ^ (k >> 1)));
            end
            if (k > 0) begin
                total++;
                if ($countones(rec_pat[k] ^ rec_pat[k-1]) != 1) begin
                    bad++; $display("FAIL gray_step%0d: %h -> %h", k, rec_pat[k-1], rec_pat[k]);
                end
            end
        end
        total++;
        if (rec_pat[31] !== 5'b10000 || done_cyc !== 64) begin
            bad++; $display("FAIL gray_last: got %h done@%0d required 10 done@64", rec_pat[31], done_cyc);
        end
        total++;
        if (a_sig !== exp_sig_a(1'b1, 32)) begin
            bad++; $display("FAIL gray_sig: got %h required %h", a_sig, exp_sig_a(1'b1, 32));
        end
    endtask

    task automatic test_back_pressure;
        int n, stall, nd, dc;
        n = 0; stall = 0; nd = 0; dc = -1;
        a_mode = 1'b0; a_ready = 1'b1;
        @(negedge CK) a_start = 1'b1;
        @(negedge CK) a_start = 1'b0;
        for (int cyc = 0; cyc < 90; cyc++) begin
            if (n == 3 && stall < 5 && (stall > 0 || a_rec_valid)) begin
                a_ready = 1'b0; stall++;
                total++;
                if (a_rec_valid !== 1'b1 || a_rec_pattern !== 5'd3 || a_stim !== 5'd3) begin
                    bad++; $display("FAIL bp_hold%0d: valid=%b pat=%h stim=%h required 1/03/03",
                        stall, a_rec_valid, a_rec_pattern, a_stim);
                end
            end else a_ready = 1'b1;
            if (a_rec_valid && a_ready && n < 64) begin rec_pat[n] = a_rec_pattern; n++; end
            if (a_done) begin nd++; if (dc < 0) dc = cyc; end
            @(negedge CK);
        end
        a_ready = 1'b1;
        total++;
        if (n !== 32) begin bad++; $display("FAIL bp_count: got %0d required 32", n); end
        for (int k = 0; k < 32; k++) begin
            total++;
            if (rec_pat[k] !== 5'(k)) begin
                bad++; $display("FAIL bp_rec%0d: got %h required %h", k, rec_pat[k], 5'(k));
            end
        end
        total++;
        if (nd !== 1 || dc !== 69) begin
            bad++; $display("FAIL bp_done: pulses=%0d at %0d required 1 at 69", nd, dc);
        end
    endtask

    task automatic test_abort;
        int n, nd;
        bit hit;
        logic [15:0] frozen;
        n = 0; nd = 0; hit = 0;
        a_mode = 1'b0; a_ready = 1'b1;
        @(negedge CK) a_start = 1'b1;
        @(negedge CK) a_start = 1'b0;
        for (int cyc = 0; cyc < 60 && !hit; cyc++) begin
            if (a_rec_valid && n == 10) begin
                a_abort = 1'b1;
                @(negedge CK) a_abort = 1'b0;
                hit = 1;
            end else begin
                if (a_rec_valid) n++;
                @(negedge CK);
            end
        end
        total++;
        if (!hit) begin bad++; $display("FAIL abort_reach: record 10 never seen, got %0d records", n); end
        total++;
        if (a_busy !== 1'b0 || a_stim !== 5'd0 || a_rec_valid !== 1'b0) begin
            bad++; $display("FAIL abort_idle: busy=%b stim=%h valid=%b required 0/00/0",
                a_busy, a_stim, a_rec_valid);
        end
        frozen = a_sig;
        total++;
        if (a_sig !== exp_sig_a(1'b0, 10)) begin
            bad++; $display("FAIL abort_sig: got %h required %h", a_sig, exp_sig_a(1'b0, 10));
        end
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (a_done) nd++;
            @(negedge CK);
        end
        total++;
        if (nd !== 0 || a_sig !== frozen) begin
            bad++; $display("FAIL abort_quiet: done=%0d sig=%h required 0 and %h", nd, a_sig, frozen);
        end
        run_a(1'b0);
        total++;
        if (n_rec !== 32 || rec_pat[0] !== 5'd0 || done_cyc !== 64) begin
            bad++; $display("FAIL abort_restart: n=%0d first=%h done@%0d required 32/00/64",
                n_rec, rec_pat[0], done_cyc);
        end
    endtask

    task automatic test_reset_mid;
        a_mode = 1'b0; a_ready = 1'b1;
        @(negedge CK) a_start = 1'b1;
        @(negedge CK) a_start = 1'b0;
        repeat (4) @(negedge CK);
        total++;
        if (a_busy !== 1'b1 || a_rec_valid !== 1'b0 || a_stim !== 5'd2) begin
            bad++; $display("FAIL rst_pre_apply: busy=%b valid=%b stim=%h required 1/0/02",
                a_busy, a_rec_valid, a_stim);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({a_stim, a_rec_valid, a_rec_pattern, a_rec_resp, a_busy, a_done, a_sig} !== '0) begin
            bad++; $display("FAIL rst_async: got %h required 0",
                {a_stim, a_rec_valid, a_rec_pattern, a_rec_resp, a_busy, a_done, a_sig});
        end
        @(negedge CK) rst_n = 1'b1;
        @(negedge CK);
    endtask

    task automatic test_signature;
        int nd, dc;
        logic [15:0] exp;
        nd = 0; dc = -1;
`ifdef SWEEPER_MISR_EN
        exp = 16'h0002;
`else
        exp = 16'h0000;
`endif
        @(negedge CK) b_start = 1'b1;
        @(negedge CK) b_start = 1'b0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (b_done) begin nd++; if (dc < 0) dc = cyc; end
            @(negedge CK);
        end
        total++;
        if (nd !== 1 || dc !== 4) begin bad++; $display("FAIL sig_done: %0d at %0d required 1 at 4", nd, dc); end
        total++;
        if (b_sig !== exp) begin bad++; $display("FAIL sig_value: got %h required %h", b_sig, exp); end
        total++;
        if (b_busy !== 1'b0 || b_stim !== 1'b0 || b_rec_valid !== 1'b0) begin
            bad++; $display("FAIL sig_idle: busy=%b stim=%b valid=%b", b_busy, b_stim, b_rec_valid);
        end
    endtask

    task automatic test_settle3;
        int n, nd, dc, ak;
        logic [15:0] s;
        n = 0; nd = 0; dc = -1; ak = 0;
        c_mode = 1'b0; c_ready = 1'b1;
        @(negedge CK) c_start = 1'b1;
        @(negedge CK) c_start = 1'b0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            // Wrong value in the first two APPLY cycles, true parity on the third.
            if (c_busy && !c_rec_valid) begin
                c_resp = (ak < 2) ? ~(^c_stim) : ^c_stim;
                ak++;
            end else ak = 0;
            if (c_rec_valid && c_ready && n < 64) begin
                rec_pat[n] = 5'(c_rec_pattern); rec_rsp[n] = c_rec_resp; n++;
            end
            if (c_done) begin nd++; if (dc < 0) dc = cyc; end
            @(negedge CK);
        end
        total++;
        if (n !== 4 || nd !== 1 || dc !== 16) begin
            bad++; $display("FAIL s3_timing: n=%0d done=%0d at %0d required 4/1/16", n, nd, dc);
        end
        s = '0;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (rec_pat[k] !== 5'(k) || rec_rsp[k] !== ^(2'(k))) begin
                bad++; $display("FAIL s3_rec%0d: got %h/%b required %h/%b",
                    k, rec_pat[k], rec_rsp[k], 5'(k), ^(2'(k)));
            end
            s = misr(s, {13'b0, 2'(k), ^(2'(k))});
        end
`ifndef SWEEPER_MISR_EN
        s = '0;
`endif
        total++;
        if (c_sig !== s) begin bad++; $display("FAIL s3_sig: got %h required %h", c_sig, s); end
    endtask

    initial begin
        test_reset;
        test_ascending;
        test_gray;
        test_back_pressure;
        test_abort;
        test_reset_mid;
        test_signature;
        test_settle3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
